// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   N-digit multiplexed common-anode 7-segment driver for the score path.
//   A binary value is accepted on a valid/busy handshake, converted to BCD by
//   a one-bit-per-clock shift-add-3 engine, committed to a display register,
//   and scanned out one digit per REFRESH_DIV clocks.
//
// Parameters
//   DIGITS      : digits scanned (BCD width 4*DIGITS)
//   VALUE_W     : binary input width
//   REFRESH_DIV : clocks per digit slot (>= 2)
//
// Ports
//   CLK, RST    : clock, synchronous active-high reset
//   enable      : 1 = display on, 0 = blank (conversion unaffected)
//   value       : binary value to display
//   value_valid : load request
//   busy        : conversion in progress
//   overflow    : last committed value was >= 10^DIGITS (display clamped)
//   seg7        : active-low segments, bit6 = a .. bit0 = g
//   COM         : active-low one-hot digit select, COM[0] = ones digit
//
// Build option
//   SEG7_LEADING_BLANK_EN : blank zero digits above the most significant
//                           non-zero digit (ones digit never blanked).

module seg7_scan_display #(
    parameter int DIGITS      = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 2500
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [VALUE_W-1:0] value,
    input  logic               value_valid,
    output logic               busy,
    output logic               overflow,
    output logic [6:0]         seg7,
    output logic [DIGITS-1:0]  COM
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // 10^DIGITS, saturated once it exceeds the input range so wide DIGITS
    // settings cannot overflow the constant.
    function automatic longint unsigned pow10_sat(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++)
            if (p <= (64'd1 << VALUE_W)) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned LIMIT = pow10_sat(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [BW-1:0]      r_bcd;
    logic [VALUE_W-1:0] r_bin;
    logic               r_ovf_cur;
    logic               r_pend_vld;
    logic [VALUE_W-1:0] r_pend_val;
    logic [BW-1:0]      r_disp;

    logic [BW-1:0]      w_adj;
    logic               w_start;
    logic [VALUE_W-1:0] w_start_val;

    // Add-3 correction applied before each shift.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++)
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end

    // A new conversion starts from IDLE on a request, or at commit when a
    // request is either arriving now (newest wins) or already pending.
    always_comb begin
        w_start     = 1'b0;
        w_start_val = value;
        if (r_state == S_IDLE) begin
            w_start = value_valid;
        end else if (r_state == S_COMMIT) begin
            w_start = value_valid || r_pend_vld;
            if (!value_valid) w_start_val = r_pend_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_ovf_cur  <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
            r_disp     <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (r_state == S_COMMIT) begin
                r_disp     <= r_ovf_cur ? {DIGITS{4'd9}} : r_bcd;
                overflow   <= r_ovf_cur;
                r_pend_vld <= 1'b0;
                r_state    <= S_IDLE;
                busy       <= 1'b0;
            end
            if (r_state == S_SHIFT) begin
                {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == CW'(VALUE_W - 1)) r_state <= S_COMMIT;
                if (value_valid) begin
                    r_pend_vld <= 1'b1;
                    r_pend_val <= value;
                end
            end
            if (w_start) begin
                r_bin     <= w_start_val;
                r_bcd     <= '0;
                r_cnt     <= '0;
                r_ovf_cur <= (64'(w_start_val) >= LIMIT);
                r_state   <= S_SHIFT;
                busy      <= 1'b1;
            end
        end
    end

    // ---------------- scan ----------------
    logic [DW-1:0] r_div;
    logic [IW-1:0] r_idx;
    logic          r_lit;
    logic          w_wrap;
    logic [IW-1:0] w_idx_nxt;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;

    assign w_wrap    = (r_div == DW'(REFRESH_DIV - 1));
    assign w_idx_nxt = !w_wrap ? r_idx : (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    assign w_nib     = r_disp[4*w_idx_nxt +: 4];

`ifdef SEG7_LEADING_BLANK_EN
    // Digit is blank when it and every digit above it are zero.
    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        w_blank = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (r_disp[4*d +: 4] != 4'd0) hi_zero = 1'b0;
            if (d == int'(w_idx_nxt)) w_blank = hi_zero;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        case (w_nib)
            4'd0:    w_seg_nxt = 7'b0000001;
            4'd1:    w_seg_nxt = 7'b1001111;
            4'd2:    w_seg_nxt = 7'b0010010;
            4'd3:    w_seg_nxt = 7'b0000110;
            4'd4:    w_seg_nxt = 7'b1001100;
            4'd5:    w_seg_nxt = 7'b0100100;
            4'd6:    w_seg_nxt = 7'b0100000;
            4'd7:    w_seg_nxt = 7'b0001111;
            4'd8:    w_seg_nxt = 7'b0000000;
            4'd9:    w_seg_nxt = 7'b0000100;
            default: w_seg_nxt = 7'b1111111;
        endcase
        if (w_blank) w_seg_nxt = 7'b1111111;
    end

    // Segments are reloaded only at a slot boundary (or when coming out of
    // blanking) so a commit mid-slot never changes a lit digit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div <= '0;
            r_idx <= '0;
            r_lit <= 1'b0;
            COM   <= '1;
            seg7  <= 7'b1111111;
        end else begin
            r_div <= w_wrap ? '0 : r_div + 1'b1;
            r_idx <= w_idx_nxt;
            r_lit <= enable;
            if (!enable) begin
                COM  <= '1;
                seg7 <= 7'b1111111;
            end else begin
                COM <= ~(DIGITS'(1) << w_idx_nxt);
                if (w_wrap || !r_lit) seg7 <= w_seg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    localparam int D  = 4;
    localparam int VW = 14;
    localparam int R  = 4;
    localparam int CL = VW + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          enable = 1'b1;
    logic [VW-1:0] value = '0;
    logic          value_valid = 1'b0;
    logic          busy, overflow;
    logic [6:0]    seg7;
    logic [D-1:0]  COM;

    seg7_scan_display #(.DIGITS(D), .VALUE_W(VW), .REFRESH_DIV(R)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .value(value),
        .value_valid(value_valid), .busy(busy), .overflow(overflow),
        .seg7(seg7), .COM(COM)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: [0] = in flight, [1] = pending (overwritten by newer)
    int q[$];
    int exp_dig[D];
    int exp_ovf = 0;
    bit scan_on = 0;

    function automatic logic [6:0] pat(input int idx);
        logic [6:0] s;
        case (exp_dig[idx])
            0: s = 7'b0000001; 1: s = 7'b1001111; 2: s = 7'b0010010;
            3: s = 7'b0000110; 4: s = 7'b1001100; 5: s = 7'b0100100;
            6: s = 7'b0100000; 7: s = 7'b0001111; 8: s = 7'b0000000;
            9: s = 7'b0000100; default: s = 7'b1111111;
        endcase
`ifdef SEG7_LEADING_BLANK_EN
        if (idx != 0) begin
            bit z;
            z = 1;
            for (int j = idx; j < D; j++) if (exp_dig[j] != 0) z = 0;
            if (z) s = 7'b1111111;
        end
`endif
        return s;
    endfunction

    function automatic void set_exp(input int v);
        if (v >= 10000) begin
            for (int d = 0; d < D; d++) exp_dig[d] = 9;
            exp_ovf = 1;
        end else begin
            int t;
            t = v;
            for (int d = 0; d < D; d++) begin exp_dig[d] = t % 10; t = t / 10; end
            exp_ovf = 0;
        end
    endfunction

    task automatic drive(input int v);
        value       = VW'(v);
        value_valid = 1'b1;
        if (q.size() < 2) q.push_back(v);
        else q[1] = v;
    endtask

    // Scan reference model: divider/index from reset, COM expected per edge.
    int m_div = 0, m_idx = 0;
    logic [D-1:0] exp_com = '1;
    always @(posedge CLK) begin
        if (RST) begin
            m_div = 0; m_idx = 0; exp_com = '1;
        end else begin
            if (m_div == R - 1) begin m_div = 0; m_idx = (m_idx + 1) % D; end
            else m_div++;
            exp_com = enable ? ~(D'(1) << m_idx) : '1;
        end
    end

    always @(negedge CLK) begin
        if (scan_on) begin
            chk("com", int'(COM), int'(exp_com));
            if (exp_com == '1) chk("seg_blank", int'(seg7), 7'h7F);
        end
    end

    // Commit monitor: busy falling edge pops the scoreboard.
    int run = 0;
    always @(negedge CLK) begin
        if (scan_on) begin
            if (busy) run++;
            else if (run > 0) begin
                if (q.size() > 0) begin
                    chk("busy_len", run, q.size() * CL);
                    set_exp(q[$]);
                    chk("ovf", int'(overflow), exp_ovf);
                    q.delete();
                end
                run = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic check_frame();
        int lit[D];
        int idx;
        for (int d = 0; d < D; d++) lit[d] = 0;
        repeat ((D + 1) * R) @(negedge CLK);
        for (int c = 0; c < D * R; c++) begin
            @(negedge CLK);
            idx = 0;
            for (int d = 0; d < D; d++) if (!COM[d]) idx = d;
            chk("com_onehot", $countones(~COM), 1);
            chk("seg", int'(seg7), int'(pat(idx)));
            lit[idx]++;
        end
        for (int d = 0; d < D; d++) chk("slot_len", lit[d], R);
    endtask

    task automatic send(input int v);
        @(negedge CLK); drive(v);
        @(negedge CLK); value_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        for (int d = 0; d < D; d++) exp_dig[d] = 0;
        repeat (3) @(negedge CLK);
        scan_on = 1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_com", int'(COM), 4'hF);
        chk("rst_seg", int'(seg7), 7'h7F);
        RST = 1'b0;
        repeat (4 * D * R) @(negedge CLK);
        check_frame();

        send(1234);  check_frame();
        send(12000); check_frame();
        send(7);     check_frame();

        // 5, 6, 9 back to back: 6 is overwritten by 9 while 5 converts
        @(negedge CLK); drive(5);
        @(negedge CLK); drive(6);
        @(negedge CLK); drive(9);
        @(negedge CLK); value_valid = 1'b0;
        wait_idle();
        check_frame();

        // blank mid-frame; COM checker tracks phase against the model
        repeat (5) @(negedge CLK);
        enable = 1'b0;
        repeat (10) @(negedge CLK);
        enable = 1'b1;
        check_frame();

        // reset during a conversion
        @(negedge CLK); drive(9999);
        @(negedge CLK); value_valid = 1'b0;
        repeat (4) @(negedge CLK);
        q.delete();
        set_exp(0);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ovf", int'(overflow), 0);
        chk("abort_com", int'(COM), 4'hF);
        RST = 1'b0;
        check_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
